// File: rtl/cam_pixel_capture_pkg.sv
// Shared camera capture types: RGB565 record, FIFO entry layout, capture FSM state and clog2.
package cam_pixel_capture_pkg;

    localparam int unsigned PIX_W   = 16;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ENTRY_W = PIX_W + 2 * COORD_W + 2;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        rgb565_t            data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
    } pix_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StActive
    } cap_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module cam_pix_fifo
    import cam_pixel_capture_pkg::*;
#(
    parameter int unsigned Width = ENTRY_W,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = clog2(Depth);
    localparam logic [AddrW:0] DepthC = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthC);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera byte-stream capture: pairs bytes into RGB565, decimates, tags coordinates and
// frame/line markers, and queues kept pixels for the frame-buffer writer.
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  cam_dat,
    input  logic        cam_href,
    input  logic        cam_vsync,
    input  logic        enable,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        overflow,
    input  logic        clear_ovf
);

    localparam int unsigned MAX_DIM = (IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT;
    localparam int unsigned CNT_W   = clog2(MAX_DIM) + 1;
    localparam logic [CNT_W-1:0] W_MAX    = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(IMG_HEIGHT);
    localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [CNT_W-1:0] EOL_X    = CNT_W'(IMG_WIDTH - (1 << DECIM_LOG2));

    cap_state_e       state_q, state_d;
    logic             href_q, vsync_q;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic             vs_rise, vs_fall, href_fall, keep, push, pop, drop;
    logic             fifo_full, fifo_empty;
    pix_entry_t       wr_entry, rd_entry;
    logic [ENTRY_W-1:0] rd_data;

    assign vs_rise   = cam_vsync & ~vsync_q;
    assign vs_fall   = ~cam_vsync & vsync_q;
    assign href_fall = href_q & ~cam_href;
    assign keep      = (x_q < W_MAX) && (y_q < H_MAX) &&
                       ((x_q & DEC_MASK) == '0) && ((y_q & DEC_MASK) == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            href_q       <= cam_href;
            vsync_q      <= cam_vsync;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        x_d          = x_q;
        y_d          = y_q;
        push         = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (vs_rise && enable) state_d = StSync;
            end
            StSync: begin
                if (vs_fall) begin
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (cam_href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = cam_dat;
                    end else begin
                        push = keep;
                        if (x_q < W_MAX) x_d = x_q + 1'b1;
                    end
                end else begin
                    // A dangling high byte from an odd-length line is simply forgotten.
                    phase_d = 1'b0;
                    if (href_fall) begin
                        x_d = '0;
                        if (x_q != '0 && y_q < H_MAX) y_d = y_q + 1'b1;
                    end
                end
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = enable ? StSync : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop  = ~fifo_empty & pix_ready;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;
    end

    always_comb begin
        wr_entry.data = rgb565_t'({hi_q, cam_dat});
        wr_entry.x    = COORD_W'(x_q >> DECIM_LOG2);
        wr_entry.y    = COORD_W'(y_q >> DECIM_LOG2);
        wr_entry.sof  = (x_q == '0) && (y_q == '0);
        wr_entry.eol  = (x_q == EOL_X);
    end

    cam_pix_fifo #(
        .Width(ENTRY_W),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (resetn),
        .push_i (push),
        .data_i (wr_entry),
        .pop_i  (pop),
        .data_o (rd_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign rd_entry   = pix_entry_t'(rd_data);
    assign pix_valid  = ~fifo_empty;
    assign pix_data   = rd_entry.data;
    assign pix_x      = rd_entry.x;
    assign pix_y      = rd_entry.y;
    assign pix_sof    = rd_entry.sof;
    assign pix_eol    = rd_entry.eol;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a scoreboard of expected pixels per instance.
module tb_cam_pixel_capture;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  cam_dat = '0;
    logic        cam_href = 1'b0, cam_vsync = 1'b0, enable = 1'b0;
    logic        pix_ready = 1'b1, clear_ovf = 1'b0;

    logic        pv_a, sof_a, eol_a, fd_a, ovf_a;
    logic [15:0] pd_a;
    logic [9:0]  px_a, py_a;
    logic        pv_b, sof_b, eol_b, fd_b, ovf_b;
    logic [15:0] pd_b;
    logic [9:0]  px_b, py_b;

    always #5 clk = ~clk;

    cam_pixel_capture #(
        .IMG_WIDTH(8), .IMG_HEIGHT(4), .DECIM_LOG2(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .resetn(resetn), .cam_dat(cam_dat), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .enable(enable), .pix_valid(pv_a), .pix_ready(pix_ready),
        .pix_data(pd_a), .pix_x(px_a), .pix_y(py_a), .pix_sof(sof_a), .pix_eol(eol_a),
        .frame_done(fd_a), .overflow(ovf_a), .clear_ovf(clear_ovf)
    );

    cam_pixel_capture #(
        .IMG_WIDTH(8), .IMG_HEIGHT(4), .DECIM_LOG2(0), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .resetn(resetn), .cam_dat(cam_dat), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .enable(enable), .pix_valid(pv_b), .pix_ready(1'b1),
        .pix_data(pd_b), .pix_x(px_b), .pix_y(py_b), .pix_sof(sof_b), .pix_eol(eol_b),
        .frame_done(fd_b), .overflow(ovf_b), .clear_ovf(clear_ovf)
    );

    int          n_checks = 0, n_pass = 0;
    logic [37:0] sb_a[$], sb_b[$];
    bit          check_a = 1'b1, check_b = 1'b0, tgt_b = 1'b0;
    int          fd_cnt = 0, pops_a = 0, pops_b = 0;
    int          model_w = 8, model_h = 4, model_d = 1, my = 0;
    logic [7:0]  bval = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] e;
        if (resetn && fd_a) fd_cnt++;
        if (resetn && check_a && pv_a && pix_ready) begin
            if (sb_a.size() == 0) begin
                chk("unexpected_pix_a", 64'(sb_a.size()), 64'd1);
            end else begin
                e = sb_a.pop_front();
                chk("pix_a", 64'({pd_a, px_a, py_a, sof_a, eol_a}), 64'(e));
                pops_a++;
            end
        end
        if (resetn && check_b && pv_b) begin
            if (sb_b.size() == 0) begin
                chk("unexpected_pix_b", 64'(sb_b.size()), 64'd1);
            end else begin
                e = sb_b.pop_front();
                chk("pix_b", 64'({pd_b, px_b, py_b, sof_b, eol_b}), 64'(e));
                pops_b++;
            end
        end
    end

    initial begin
        #2000000;
        $error("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [37:0] e);
        if (tgt_b) sb_b.push_back(e);
        else sb_a.push_back(e);
    endtask

    // mode 0: nothing expected, 1: every kept pixel, 2: kept pixels until 4 are queued
    task automatic send_line(input int nbytes, input int mode);
        int         px;
        logic [7:0] b0;
        px = 0;
        b0 = '0;
        for (int i = 0; i < nbytes; i++) begin
            cam_dat  = bval;
            cam_href = 1'b1;
            if (i % 2 == 0) begin
                b0 = bval;
            end else begin
                if (mode != 0 && px < model_w && my < model_h &&
                    px % (1 << model_d) == 0 && my % (1 << model_d) == 0 &&
                    (mode == 1 || sb_a.size() < 4))
                    push_exp({b0, bval, 10'(px >> model_d), 10'(my >> model_d),
                              (px == 0 && my == 0), (px == model_w - (1 << model_d))});
                px++;
            end
            bval++;
            tick();
        end
        cam_href = 1'b0;
        if (px > 0) my++;
        tick();
        tick();
    endtask

    task automatic send_frame(input int mode);
        for (int l = 0; l < 4; l++) send_line(16, mode);
    endtask

    task automatic vs_high();
        cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic vs_low();
        cam_vsync = 1'b0;
        repeat (3) tick();
        my = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb_a.size() + sb_b.size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 64'(sb_a.size() + sb_b.size()), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 64'(pv_a), 64'd0);
        chk("rst_head", 64'({pd_a, px_a, py_a, sof_a, eol_a}), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_fd", 64'(fd_a), 64'd0);
        resetn = 1'b1;
        enable = 1'b1;
        tick();

        // Full 8x4 frame, consumer always ready
        vs_high();
        vs_low();
        send_frame(1);
        vs_high();
        drain("t1_drain");
        chk("t1_pops", 64'(pops_a), 64'd8);
        chk("t1_fd", 64'(fd_cnt), 64'd1);
        chk("t1_ovf", 64'(ovf_a), 64'd0);

        // Same frame with consumer stalled: 4 held, rest dropped
        pix_ready = 1'b0;
        bval = '0;
        vs_low();
        send_frame(2);
        chk("t2_valid", 64'(pv_a), 64'd1);
        chk("t2_ovf", 64'(ovf_a), 64'd1);
        vs_high();
        chk("t2_fd", 64'(fd_cnt), 64'd2);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t2_ovf_clr", 64'(ovf_a), 64'd0);
        pix_ready = 1'b1;
        drain("t2_drain");
        chk("t2_pops", 64'(pops_a), 64'd12);

        // Odd byte count on a line
        bval = '0;
        vs_low();
        send_line(3, 1);
        send_line(4, 1);
        send_line(4, 1);
        vs_high();
        drain("t3_drain");
        chk("t3_pops", 64'(pops_a), 64'd14);
        chk("t3_fd", 64'(fd_cnt), 64'd3);

        // enable dropped mid-frame
        bval = '0;
        vs_low();
        send_line(16, 1);
        enable = 1'b0;
        send_line(16, 1);
        send_line(16, 1);
        send_line(16, 1);
        vs_high();
        chk("t4_fd", 64'(fd_cnt), 64'd4);
        drain("t4_drain");
        chk("t4_pops", 64'(pops_a), 64'd22);
        vs_low();
        send_frame(0);
        vs_high();
        chk("t4_idle_fd", 64'(fd_cnt), 64'd4);
        chk("t4_idle_valid", 64'(pv_a), 64'd0);
        chk("t4_idle_pops", 64'(pops_a), 64'd22);
        vs_low();

        // Reset mid-line
        enable = 1'b1;
        vs_high();
        vs_low();
        pix_ready = 1'b0;
        bval = '0;
        for (int i = 0; i < 6; i++) begin
            cam_dat  = bval;
            cam_href = 1'b1;
            bval++;
            tick();
        end
        chk("t5_pre_valid", 64'(pv_a), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(pv_a), 64'd0);
        sb_a.delete();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cam_dat = bval;
            bval++;
            tick();
        end
        cam_href = 1'b0;
        pix_ready = 1'b1;
        repeat (4) tick();
        chk("t5_idle_valid", 64'(pv_a), 64'd0);
        bval = '0;
        vs_high();
        vs_low();
        send_frame(1);
        vs_high();
        drain("t5_drain");
        chk("t5_pops", 64'(pops_a), 64'd30);
        chk("t5_fd", 64'(fd_cnt), 64'd5);

        // Over-long line, no decimation
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_a = 1'b0;
        check_b = 1'b1;
        tgt_b = 1'b1;
        model_d = 0;
        bval = '0;
        vs_high();
        vs_low();
        send_line(20, 1);
        drain("t6_drain");
        chk("t6_pops", 64'(pops_b), 64'd8);
        chk("t6_ovf", 64'(ovf_b), 64'd0);
        chk("t6_valid", 64'(pv_b), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Downstream of the camera pad/IO-register stage. Consumes the registered OV-style byte stream (cam_dat, cam_href, cam_vsync) in the camera clock domain.
- Assembles byte pairs into RGB565 pixels and decimates by 2^DECIM_LOG2 in x and y.
- Tags each kept pixel with output coordinates and frame/line markers.
- Delivers pixels through a small FIFO with a valid/ready handshake to the frame-buffer writer.

Parameters:
IMG_WIDTH, 640, incoming pixels per line (2 bytes each)
IMG_HEIGHT, 480, incoming lines per frame
DECIM_LOG2, 2, keep 1 of every 2^DECIM_LOG2 pixels in x and in y (0 = no decimation)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  camera pixel clock (cam_xclk_internal); single clock domain
resetn  in  1  asynchronous active-low reset
cam_dat  in  8  registered camera data byte
cam_href  in  1  registered line-valid
cam_vsync  in  1  registered frame sync (high = vertical blanking)
enable  in  1  capture enable, sampled at frame boundary
pix_valid  out  1  FIFO head valid
pix_ready  in  1  consumer accepts head when pix_valid & pix_ready
pix_data  out  16  RGB565 pixel {first byte, second byte}
pix_x  out  10  output column (incoming x >> DECIM_LOG2)
pix_y  out  10  output row (incoming y >> DECIM_LOG2)
pix_sof  out  1  head is first kept pixel of frame
pix_eol  out  1  head is last kept pixel of a kept line
frame_done  out  1  one-cycle pulse at end of a captured frame
overflow  out  1  sticky: a kept pixel was dropped because FIFO full
clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset values: all outputs 0, FIFO empty, all counters 0, state IDLE.
- Reset mid-frame discards everything. Capture restarts only at the next vsync rising edge.
- Edge detection uses one-cycle-delayed copies of href and vsync.
- FSM states:
  - IDLE: on vsync rise with enable = 1, go to SYNC.
  - SYNC (vsync high): on vsync fall, clear x, y and byte phase, then go to ACTIVE.
  - ACTIVE: on vsync rise, pulse frame_done, then go to SYNC if enable = 1, else IDLE.
- enable is sampled only on vsync rise. Deasserting it mid-frame does not abort the current frame.
- Byte phase:
  - Toggles on every cycle with href = 1 in ACTIVE.
  - Phase 0 latches the high byte. Phase 1 completes the pixel.
  - href falling with phase = 1 (odd byte count) discards the partial byte.
  - Phase resets to 0 whenever href = 0.
- x counter: increments per completed pixel and clears on href fall. Pixels with x >= IMG_WIDTH are dropped and x saturates.
- y counter: increments on href fall if at least one pixel completed on the line. Lines with y >= IMG_HEIGHT are dropped.
- Keep rule: a pixel is kept iff x[DECIM_LOG2-1:0] == 0 and y[DECIM_LOG2-1:0] == 0.
- pix_sof = 1 for the kept pixel with x = 0, y = 0.
- pix_eol = 1 for the kept pixel with x = IMG_WIDTH - 2^DECIM_LOG2. A line shorter than IMG_WIDTH produces no eol.
- FIFO write: a kept pixel is written the same cycle phase-1 is sampled. Its entry is visible at the FIFO head (pix_valid = 1 if the FIFO was empty) on the next cycle, i.e. 1-cycle latency from the second byte.
- Full FIFO:
  - A kept pixel arriving while full is dropped and overflow sets.
  - A simultaneous pop and push when full succeeds; no drop.
- Outputs are stable while pix_valid = 1 and pix_ready = 0.
- overflow: clear_ovf clears it; a new drop in the same cycle wins (overflow stays 1).
- frame_done asserts regardless of FIFO contents. Pixels already in the FIFO still drain.
- Width rules:
  - x/y counters: clog2(max(IMG_WIDTH, IMG_HEIGHT)) + 1 bits, saturating.
  - pix_x/pix_y: zero-extended to 10 bits.

Decomposition:
- Shared camera package holds the RGB565 record/width constants, the pix-entry width (16 + 10 + 10 + 2 = 38 bits), the FSM state type and clog2.
- One sub-module, cam_pix_fifo: synchronous FIFO, width 38, depth FIFO_DEPTH, with a show-ahead head, full/empty flags and simultaneous push/pop when full.

Test Plan:
- 8x4 frame (IMG_WIDTH=8, IMG_HEIGHT=4, DECIM_LOG2=1), ready tied 1, bytes 0x00..0x3F in order -> 8 pixels.
  - First pixel: data 0x0001 at (0,0) with sof.
  - Row 0 eol pixel: data 0x0C0D at (3,0).
  - Row 1 first pixel: data 0x2021 at (0,1).
  - frame_done pulses once after vsync rise.
- Same frame with pix_ready = 0 throughout -> 4 pixels held (FIFO_DEPTH=4), remaining 4 dropped, overflow = 1. clear_ovf -> overflow = 0.
- href drops after 3 bytes (odd count) -> one pixel, 0x0001; the partial byte is discarded and the next line starts at phase 0.
- enable deasserted mid-frame -> current frame completes with frame_done; the next vsync leaves the FSM in IDLE and no pixels are produced.
- resetn pulsed low mid-line -> pix_valid = 0 and FIFO empty immediately. No pixels until the vsync rise/fall that follows reset release; the first pixel after that has sof at (0,0).
- Line of 10 pixels with IMG_WIDTH=8 and DECIM_LOG2=0 -> exactly 8 pixels output, eol on x=7, extra pixels dropped without setting overflow.
